// File: rtl/jzjpcc_scoreboard_hazard_unit.sv
// Hazard unit for the jzjpcc pipeline: execute-stage bypass, load-use and scoreboard stalls, branch flush.
// Optional performance counters are enabled with JZJPCC_HAZARD_PERF_EN.
module jzjpcc_scoreboard_hazard_unit #(
  parameter int XLEN                = 32,
  parameter int NUM_SRC             = 2,
  parameter int BRANCH_FLUSH_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [5*NUM_SRC-1:0]    rsAddr_decode,
  input  logic [5*NUM_SRC-1:0]    rsAddr_execute,
  input  logic [4:0]              rdAddr_decode,
  input  logic                    rdWriteEnable_decode,
  input  logic [4:0]              rdAddr_execute,
  input  logic                    rdWriteEnable_execute,
  input  logic                    memRead_execute,
  input  logic                    mcIssue_execute,
  input  logic                    mcComplete,
  input  logic [4:0]              mcRdAddr,
  input  logic [4:0]              rdAddr_memory,
  input  logic                    rdWriteEnable_memory,
  input  logic [XLEN-1:0]         aluResult_memory,
  input  logic [4:0]              rdAddr_writeback,
  input  logic                    rdWriteEnable_writeback,
  input  logic [XLEN-1:0]         rd_writebackEnd,
  input  logic                    branchTaken_execute,
  output logic                    stall_fetch,
  output logic                    stall_decode,
  output logic                    flush_decode,
  output logic                    flush_execute,
  output logic [NUM_SRC-1:0]      bypass_execute,
  output logic [XLEN*NUM_SRC-1:0] bypassValue_execute,
  output logic [31:0]             pending
`ifdef JZJPCC_HAZARD_PERF_EN
  ,
  output logic [31:0]             stallCycles,
  output logic [31:0]             flushEvents
`endif
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(BRANCH_FLUSH_CYCLES - 1);

  logic [31:0] pending_q;
  logic [31:0] mc_clr_mask;
  logic [31:0] mc_set_mask;
  logic [31:0] pend_eff;
  logic [3:0]  flush_cnt_q;
  logic        flush_active;
  logic        load_use;
  logic        sb_stall;

  // Completion releases its register combinationally; the register file is write-first.
  assign mc_clr_mask = mcComplete ? (32'd1 << mcRdAddr) : 32'd0;
  assign mc_set_mask = (mcIssue_execute && rdAddr_execute != 5'd0) ? (32'd1 << rdAddr_execute) : 32'd0;
  assign pend_eff    = pending_q & ~mc_clr_mask;
  assign pending     = pending_q;

  assign flush_active = branchTaken_execute | (flush_cnt_q != 4'd0);

  always_comb begin
    bypass_execute      = '0;
    bypassValue_execute = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rsAddr_execute[5*i +: 5] != 5'd0 && rdWriteEnable_memory &&
            rsAddr_execute[5*i +: 5] == rdAddr_memory) begin
          bypass_execute[i]                   = 1'b1;
          bypassValue_execute[XLEN*i +: XLEN] = aluResult_memory;
        end else if (rsAddr_execute[5*i +: 5] != 5'd0 && rdWriteEnable_writeback &&
                     rsAddr_execute[5*i +: 5] == rdAddr_writeback) begin
          bypass_execute[i]                   = 1'b1;
          bypassValue_execute[XLEN*i +: XLEN] = rd_writebackEnd;
        end
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    sb_stall = rdWriteEnable_decode & pend_eff[rdAddr_decode];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (memRead_execute && rdWriteEnable_execute && rdAddr_execute != 5'd0 &&
          rsAddr_decode[5*i +: 5] == rdAddr_execute)
        load_use = 1'b1;
      if (rsAddr_decode[5*i +: 5] != 5'd0 && pend_eff[rsAddr_decode[5*i +: 5]])
        sb_stall = 1'b1;
    end
  end

  // While reset is held the pipeline is bubbled rather than stalled.
  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    if (reset || flush_active) begin
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else if (load_use || sb_stall) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      flush_execute = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q   <= 32'd0;
      flush_cnt_q <= 4'd0;
    end else begin
      pending_q <= ((pending_q & ~mc_clr_mask) | mc_set_mask) & ~32'd1;
      if (branchTaken_execute)
        flush_cnt_q <= FLUSH_RELOAD;
      else if (flush_cnt_q != 4'd0)
        flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end

`ifdef JZJPCC_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  assign stallCycles = stall_cycles_q;
  assign flushEvents = flush_events_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      if (stall_decode && stall_cycles_q != 32'hFFFF_FFFF)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branchTaken_execute && flush_events_q != 32'hFFFF_FFFF)
        flush_events_q <= flush_events_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jzjpcc_scoreboard_hazard_unit.sv
// Directed self-checking bench for jzjpcc_scoreboard_hazard_unit (NUM_SRC=2, BRANCH_FLUSH_CYCLES=3).
module tb_jzjpcc_scoreboard_hazard_unit;

  localparam int XLEN = 32;
  localparam int NSRC = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [5*NSRC-1:0] rsAddr_decode, rsAddr_execute;
  logic [4:0]        rdAddr_decode, rdAddr_execute, mcRdAddr, rdAddr_memory, rdAddr_writeback;
  logic              rdWriteEnable_decode, rdWriteEnable_execute, memRead_execute;
  logic              mcIssue_execute, mcComplete, rdWriteEnable_memory, rdWriteEnable_writeback;
  logic [XLEN-1:0]   aluResult_memory, rd_writebackEnd;
  logic              branchTaken_execute;
  logic              stall_fetch, stall_decode, flush_decode, flush_execute;
  logic [NSRC-1:0]   bypass_execute;
  logic [XLEN*NSRC-1:0] bypassValue_execute;
  logic [31:0]       pending;
`ifdef JZJPCC_HAZARD_PERF_EN
  logic [31:0]       stallCycles, flushEvents;
`endif

  int n_total = 0;
  int n_pass  = 0;

  jzjpcc_scoreboard_hazard_unit #(.XLEN(XLEN), .NUM_SRC(NSRC), .BRANCH_FLUSH_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .rsAddr_decode(rsAddr_decode), .rsAddr_execute(rsAddr_execute),
    .rdAddr_decode(rdAddr_decode), .rdWriteEnable_decode(rdWriteEnable_decode),
    .rdAddr_execute(rdAddr_execute), .rdWriteEnable_execute(rdWriteEnable_execute),
    .memRead_execute(memRead_execute), .mcIssue_execute(mcIssue_execute),
    .mcComplete(mcComplete), .mcRdAddr(mcRdAddr),
    .rdAddr_memory(rdAddr_memory), .rdWriteEnable_memory(rdWriteEnable_memory),
    .aluResult_memory(aluResult_memory),
    .rdAddr_writeback(rdAddr_writeback), .rdWriteEnable_writeback(rdWriteEnable_writeback),
    .rd_writebackEnd(rd_writebackEnd),
    .branchTaken_execute(branchTaken_execute),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_decode(flush_decode), .flush_execute(flush_execute),
    .bypass_execute(bypass_execute), .bypassValue_execute(bypassValue_execute),
    .pending(pending)
`ifdef JZJPCC_HAZARD_PERF_EN
    , .stallCycles(stallCycles), .flushEvents(flushEvents)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic clr();
    rsAddr_decode = '0; rsAddr_execute = '0;
    rdAddr_decode = '0; rdWriteEnable_decode = 1'b0;
    rdAddr_execute = '0; rdWriteEnable_execute = 1'b0; memRead_execute = 1'b0;
    mcIssue_execute = 1'b0; mcComplete = 1'b0; mcRdAddr = '0;
    rdAddr_memory = '0; rdWriteEnable_memory = 1'b0; aluResult_memory = '0;
    rdAddr_writeback = '0; rdWriteEnable_writeback = 1'b0; rd_writebackEnd = '0;
    branchTaken_execute = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    // Bypass-worthy inputs while in reset must not leak through.
    rsAddr_execute = {5'd0, 5'd5}; rdAddr_memory = 5'd5; rdWriteEnable_memory = 1'b1;
    #2;
    chk("rst_flush_decode",  64'(flush_decode), 64'd1);
    chk("rst_flush_execute", 64'(flush_execute), 64'd1);
    chk("rst_stall_fetch",   64'(stall_fetch), 64'd0);
    chk("rst_bypass",        64'(bypass_execute), 64'd0);
    chk("rst_pending",       64'(pending), 64'd0);

    cyc(); reset = 1'b0; clr();
    rsAddr_execute = {5'd0, 5'd5};
    rdAddr_memory = 5'd5; rdWriteEnable_memory = 1'b1; aluResult_memory = 32'hAAAA0001;
    rdAddr_writeback = 5'd5; rdWriteEnable_writeback = 1'b1; rd_writebackEnd = 32'h2;
    sample();
    chk("byp_mem_sel",   64'(bypass_execute), 64'd1);
    chk("byp_mem_val",   64'(bypassValue_execute), 64'h0000_0000_AAAA_0001);
    chk("idle_flush",    64'(flush_decode), 64'd0);

    cyc(); rsAddr_execute = '0;
    sample();
    chk("byp_x0_sel", 64'(bypass_execute), 64'd0);
    chk("byp_x0_val", 64'(bypassValue_execute), 64'd0);

    cyc(); rsAddr_execute = {5'd6, 5'd0}; rdAddr_writeback = 5'd6;
    sample();
    chk("byp_wb_sel", 64'(bypass_execute), 64'd2);
    chk("byp_wb_val", 64'(bypassValue_execute), 64'h0000_0002_0000_0000);

    // Load-use on decode operand 1.
    cyc(); clr();
    memRead_execute = 1'b1; rdWriteEnable_execute = 1'b1; rdAddr_execute = 5'd7;
    rsAddr_decode = {5'd7, 5'd1};
    sample();
    chk("lu_stall_fetch",   64'(stall_fetch), 64'd1);
    chk("lu_stall_decode",  64'(stall_decode), 64'd1);
    chk("lu_flush_execute", 64'(flush_execute), 64'd1);
    chk("lu_flush_decode",  64'(flush_decode), 64'd0);
    cyc(); memRead_execute = 1'b0; rdWriteEnable_execute = 1'b0; rdAddr_execute = 5'd0;
    rdAddr_memory = 5'd7; rdWriteEnable_memory = 1'b1;
    sample();
    chk("lu_release_stall", 64'(stall_decode), 64'd0);
    chk("lu_release_flush", 64'(flush_execute), 64'd0);

    // Multi-cycle write to x9, consumer waits until completion.
    cyc(); clr(); mcIssue_execute = 1'b1; rdAddr_execute = 5'd9; rdWriteEnable_execute = 1'b1;
    sample();
    chk("sb_issue_nostall", 64'(stall_decode), 64'd0);
    cyc(); clr(); rsAddr_decode = {5'd0, 5'd9};
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("sb_stall_c%0d", k + 1), 64'(stall_decode), 64'd1);
      chk($sformatf("sb_pend_c%0d", k + 1), 64'(pending), 64'h200);
      cyc();
    end
    mcComplete = 1'b1; mcRdAddr = 5'd9;
    sample();
    chk("sb_release_stall", 64'(stall_decode), 64'd0);
    chk("sb_release_flush", 64'(flush_execute), 64'd0);
    cyc(); clr();
    sample();
    chk("sb_pend_cleared", 64'(pending), 64'd0);

    // WAW against pending x12.
    cyc(); clr(); mcIssue_execute = 1'b1; rdAddr_execute = 5'd12;
    cyc(); clr(); rdAddr_decode = 5'd12; rdWriteEnable_decode = 1'b1; rsAddr_decode = {5'd1, 5'd2};
    sample();
    chk("waw_stall",   64'(stall_decode), 64'd1);
    chk("waw_pending", 64'(pending), 64'h1000);
    cyc(); rdWriteEnable_decode = 1'b0;
    sample();
    chk("waw_no_we", 64'(stall_decode), 64'd0);
    cyc(); clr(); mcComplete = 1'b1; mcRdAddr = 5'd12;
    cyc(); clr();
    sample();
    chk("waw_cleared", 64'(pending), 64'd0);

    // Issue and completion of the same register in one cycle: set wins.
    cyc(); clr(); mcIssue_execute = 1'b1; rdAddr_execute = 5'd3; mcComplete = 1'b1; mcRdAddr = 5'd3;
    cyc(); clr(); mcIssue_execute = 1'b1; rdAddr_execute = 5'd0; mcComplete = 1'b1; mcRdAddr = 5'd20;
    sample();
    chk("same_cycle_set", 64'(pending), 64'h8);
    cyc(); clr();
    sample();
    chk("issue_x0_nop", 64'(pending), 64'h8);

    // Branch while decode is stalled on pending x3: flush wins for 3 cycles.
    cyc(); rsAddr_decode = {5'd0, 5'd3}; branchTaken_execute = 1'b1;
    sample();
    chk("br_c0_flush_d", 64'(flush_decode), 64'd1);
    chk("br_c0_flush_e", 64'(flush_execute), 64'd1);
    chk("br_c0_stall",   64'(stall_decode), 64'd0);
    cyc(); branchTaken_execute = 1'b0;
    sample();
    chk("br_c1_flush_d", 64'(flush_decode), 64'd1);
    chk("br_c1_stall",   64'(stall_fetch), 64'd0);
    cyc();
    sample();
    chk("br_c2_flush_d", 64'(flush_decode), 64'd1);
    chk("br_c2_flush_e", 64'(flush_execute), 64'd1);
    chk("br_c2_stall",   64'(stall_decode), 64'd0);
    cyc();
    sample();
    chk("br_c3_flush_d", 64'(flush_decode), 64'd0);
    chk("br_c3_stall",   64'(stall_decode), 64'd1);
    chk("br_c3_flush_e", 64'(flush_execute), 64'd1);

    // Reset during an active flush with x3 still pending.
    cyc(); clr(); branchTaken_execute = 1'b1;
    cyc(); branchTaken_execute = 1'b0;
    sample();
    chk("mid_flush_active", 64'(flush_decode), 64'd1);
    chk("pre_rst_pending",  64'(pending), 64'h8);
    reset = 1'b1;
    #1;
    chk("async_rst_pending", 64'(pending), 64'd0);
    chk("async_rst_flush",   64'(flush_decode), 64'd1);
    chk("async_rst_stall",   64'(stall_decode), 64'd0);
    cyc(); reset = 1'b0;
    sample();
    chk("post_rst_flush_d", 64'(flush_decode), 64'd0);
    chk("post_rst_flush_e", 64'(flush_execute), 64'd0);

    // Back-to-back branches reload the counter.
    cyc(); branchTaken_execute = 1'b1;
    cyc(); branchTaken_execute = 1'b1;
    cyc(); branchTaken_execute = 1'b0;
    cyc();
    sample();
    chk("reload_c3_flush", 64'(flush_decode), 64'd1);
    cyc();
    sample();
    chk("reload_c4_flush", 64'(flush_decode), 64'd0);

`ifdef JZJPCC_HAZARD_PERF_EN
    cyc(); clr(); reset = 1'b1;
    cyc(); reset = 1'b0;
    memRead_execute = 1'b1; rdWriteEnable_execute = 1'b1; rdAddr_execute = 5'd7;
    rsAddr_decode = {5'd7, 5'd0};
    cyc(); cyc(); cyc(); cyc(); clr();
    branchTaken_execute = 1'b1;
    cyc(); branchTaken_execute = 1'b0;
    cyc(); cyc(); cyc(); branchTaken_execute = 1'b1;
    cyc(); branchTaken_execute = 1'b0;
    cyc(); cyc(); cyc();
    sample();
    chk("perf_stall_cycles", 64'(stallCycles), 64'd4);
    chk("perf_flush_events", 64'(flushEvents), 64'd2);
    cyc();
    dut.stall_cycles_q = 32'hFFFF_FFFE;
    memRead_execute = 1'b1; rdWriteEnable_execute = 1'b1; rdAddr_execute = 5'd7;
    rsAddr_decode = {5'd7, 5'd0};
    cyc(); cyc(); cyc(); clr();
    sample();
    chk("perf_saturate", 64'(stallCycles), 64'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
